// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI register-command master.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int unsigned FRAME_LEN  = 16;
  localparam int unsigned WR_BIT_POS = 7;
  localparam logic        RSVD_BIT   = 1'b0;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Command byte {write, reserved, addr} followed by write data or zero for a read.
  function automatic logic [FRAME_LEN-1:0] build_frame(input req_t req);
    logic [DATA_W-1:0] cmd;
    cmd                 = '0;
    cmd[ADDR_W-1:0]     = req.addr;
    cmd[WR_BIT_POS-1]   = RSVD_BIT;
    cmd[WR_BIT_POS]     = req.write;
    return {cmd, (req.write ? req.wdata : DATA_W'(0))};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: sclk with CLK_DIV-cycle half periods, idle low while disabled.
// o_rise_c / o_fall_c flag the clk edge on which sclk will go high / low.
module spi_sclk_gen
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap   = i_en && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_rise_c = w_wrap && !r_sclk;
  assign o_fall_c = w_wrap && r_sclk;
  assign o_sclk   = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 register-command master: 16-bit frames {cmd, data}, one transaction at a time.
// Define SPI_MASTER_IDLE_GAP_EN to hold cs_n high for IDLE_GAP extra cycles after each frame.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

`ifdef SPI_MASTER_IDLE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int unsigned GAP_CNT_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_tx;
  logic [DATA_W-1:0]      r_rx;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;
  logic                   r_write;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic [DATA_W-1:0]      r_rsp_rdata;
  logic                   r_cs_n;
  logic                   r_mosi;

  req_t                   w_req;
  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_sclk_en;
  logic                   w_rise_c;
  logic                   w_fall_c;
  logic                   w_sclk;

  assign w_req     = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign w_frame   = build_frame(w_req);
  assign w_sclk_en = (r_state == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_sclk_en),
    .o_sclk   (w_sclk),
    .o_rise_c (w_rise_c),
    .o_fall_c (w_fall_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bit_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_state     <= ST_SHIFT;
            r_req_ready <= 1'b0;
            r_cs_n      <= 1'b0;
            r_tx        <= w_frame;
            r_mosi      <= w_frame[FRAME_LEN-1];
            r_write     <= req_write;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Only the data byte is captured; miso during the command byte is don't-care.
          if (w_rise_c && (r_bit_cnt >= BIT_CNT_W'(DATA_W))) begin
            r_rx <= {r_rx[DATA_W-2:0], miso};
          end
          if (w_fall_c) begin
            if (r_bit_cnt == BIT_CNT_W'(FRAME_LEN - 1)) begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= '0;
              r_mosi     <= 1'b0;
            end else begin
              r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
              r_tx       <= {r_tx[FRAME_LEN-2:0], 1'b0};
              r_mosi     <= r_tx[FRAME_LEN-2];
            end
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == CNT_W'(CLK_DIV - 1)) begin
            r_cs_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? DATA_W'(0) : r_rx;
            r_gap_cnt   <= '0;
            r_state     <= (GAP_EN && (IDLE_GAP != 0)) ? ST_GAP : ST_IDLE;
          end else begin
            r_hold_cnt  <= r_hold_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_CNT_W'(IDLE_GAP - 1)) begin
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign sclk      = w_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;

endmodule
